// File: rtl/trng_controller.sv
// trng_controller: sequencer for a ring-oscillator TRNG sampler. Enforces an
// oscillator warm-up, paces sampling, packs bits into words and health-tests them.
module trng_controller #(
  parameter int WORD_WIDTH    = 32,
  parameter int WARMUP_CYCLES = 256,
  parameter int SAMPLE_DIV    = 4,
  parameter int REP_LIMIT     = 16
) (
  input  logic                  iClk,
  input  logic                  iRstn,
  input  logic                  iStart,
  input  logic                  iClearFail,
  input  logic                  iRandomBit,
  input  logic                  iReady,
  output logic                  oEntropyEn,
  output logic                  oSampleEn,
  output logic [WORD_WIDTH-1:0] oData,
  output logic                  oValid,
  output logic                  oBusy,
  output logic                  oFail
);

  localparam int WC_W  = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int BC_W  = $clog2(WORD_WIDTH);

  localparam logic [WC_W-1:0]  WARM_LAST = WC_W'(WARMUP_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(WORD_WIDTH - 1);
  localparam logic [7:0]       REP_MAX   = 8'(REP_LIMIT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WARMUP  = 3'd1,
    COLLECT = 3'd2,
    HOLD    = 3'd3,
    FAIL    = 3'd4
  } state_t;

  typedef struct packed {
    logic [WC_W-1:0]       warm_cnt;
    logic [DIV_W-1:0]      div;
    logic [BC_W-1:0]       bit_cnt;
    logic [7:0]            run;
    logic                  prev;
    logic [WORD_WIDTH-1:0] shreg;
    logic [WORD_WIDTH-1:0] data;
    logic                  valid;
    logic                  active;   // oscillator enable; also the busy flag
    logic                  sample;
    logic                  capture;  // sampler bit is valid this cycle
    logic                  fail;
  } regs_t;

  state_t state_q, state_d;
  regs_t  r_q, r_d;

  logic [7:0]            new_run;
  logic [WORD_WIDTH-1:0] new_word;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q <= IDLE;
    end else begin
      // NOTE: registers are always written with <= so every flop samples the
      // pre-edge values regardless of process ordering.
      state_q <= state_d;
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d   = state_q;
    r_d       = r_q;
    r_d.sample  = 1'b0;
    r_d.capture = 1'b0;

    if (r_q.run == 8'd0 || iRandomBit != r_q.prev) begin
      new_run = 8'd1;
    end else if (r_q.run == 8'hFF) begin
      new_run = r_q.run;
    end else begin
      new_run = r_q.run + 8'd1;
    end
    new_word = {r_q.shreg[WORD_WIDTH-2:0], iRandomBit};

    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d    = WARMUP;
          r_d.warm_cnt = '0;
          r_d.div      = '0;
          r_d.bit_cnt  = '0;
          r_d.run      = '0;
          r_d.shreg    = '0;
        end
      end

      WARMUP: begin
        if (!iStart) begin
          state_d = IDLE;
        end else if (r_q.warm_cnt == WARM_LAST) begin
          state_d = COLLECT;
          r_d.div = '0;
        end else begin
          r_d.warm_cnt = r_q.warm_cnt + 1'b1;
        end
      end

      COLLECT: begin
        if (!iStart) begin
          // Abandon the partial word; an outstanding capture dies with it.
          state_d     = IDLE;
          r_d.shreg   = '0;
          r_d.bit_cnt = '0;
        end else begin
          r_d.div     = (r_q.div == DIV_LAST) ? '0 : r_q.div + 1'b1;
          r_d.sample  = (r_q.div == DIV_LAST);
          r_d.capture = r_q.sample;
          if (r_q.capture) begin
            r_d.run  = new_run;
            r_d.prev = iRandomBit;
            // Health failure outranks word completion.
            if (new_run >= REP_MAX) begin
              state_d     = FAIL;
              r_d.sample  = 1'b0;
              r_d.capture = 1'b0;
              r_d.shreg   = '0;
              r_d.bit_cnt = '0;
              r_d.fail    = 1'b1;
            end else if (r_q.bit_cnt == BIT_LAST) begin
              state_d     = HOLD;
              r_d.data    = new_word;
              r_d.valid   = 1'b1;
              r_d.sample  = 1'b0;
              r_d.capture = 1'b0;
              r_d.shreg   = '0;
            end else begin
              r_d.shreg   = new_word;
              r_d.bit_cnt = r_q.bit_cnt + 1'b1;
            end
          end
        end
      end

      HOLD: begin
        if (iReady) begin
          r_d.valid   = 1'b0;
          r_d.bit_cnt = '0;
          r_d.div     = '0;
          state_d     = iStart ? COLLECT : IDLE;
        end
      end

      FAIL: begin
        if (iClearFail) begin
          state_d  = IDLE;
          r_d.fail = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    r_d.active = (state_d == WARMUP) || (state_d == COLLECT) || (state_d == HOLD);
  end

  assign oEntropyEn = r_q.active;
  assign oBusy      = r_q.active;
  assign oSampleEn  = r_q.sample;
  assign oData      = r_q.data;
  assign oValid     = r_q.valid;
  assign oFail      = r_q.fail;

endmodule

// File: tb/tb_trng_controller.sv
// Directed bench for trng_controller: warm-up/sample timing, word packing,
// backpressure, health failures, stop/restart and asynchronous reset.
module tb_trng_controller;

  localparam int W = 8;

  logic         iClk;
  logic         iRstn;
  logic         iStart;
  logic         iClearFail;
  logic         iRandomBit;
  logic         iReady;
  logic         oEntropyEn;
  logic         oSampleEn;
  logic [W-1:0] oData;
  logic         oValid;
  logic         oBusy;
  logic         oFail;

  int n_cmp  = 0;
  int n_bad  = 0;
  bit bits[$];

  trng_controller #(
    .WORD_WIDTH   (W),
    .WARMUP_CYCLES(4),
    .SAMPLE_DIV   (2),
    .REP_LIMIT    (4)
  ) dut (
    .iClk      (iClk),
    .iRstn     (iRstn),
    .iStart    (iStart),
    .iClearFail(iClearFail),
    .iRandomBit(iRandomBit),
    .iReady    (iReady),
    .oEntropyEn(oEntropyEn),
    .oSampleEn (oSampleEn),
    .oData     (oData),
    .oValid    (oValid),
    .oBusy     (oBusy),
    .oFail     (oFail)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Registered sampler model: a strobe seen mid-cycle yields the next bit,
  // which is then stable from the following edge on.
  always @(negedge iClk) begin
    if (oSampleEn) begin
      if (bits.size() > 0) iRandomBit = bits.pop_front();
      else                 iRandomBit = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic load_bits(input logic [15:0] v, input int n);
    bits.delete();
    for (int i = n - 1; i >= 0; i--) bits.push_back(v[i]);
  endtask

  task automatic wait_sample(input int max, output int n);
    n = 0;
    while (!oSampleEn && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!oValid && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_fail(input int max, output int n, output logic seen_valid);
    n = 0;
    seen_valid = 1'b0;
    while (!oFail && n < max) begin
      tick();
      n++;
      seen_valid |= oValid;
    end
  endtask

  initial begin
    int   n;
    logic sv;
    logic stable;

    iRstn = 1'b0; iStart = 1'b0; iClearFail = 1'b0; iRandomBit = 1'b0; iReady = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    check("rst_outs", {oEntropyEn, oSampleEn, oValid, oBusy, oFail, oData}, 64'h0);
    iRstn = 1'b1;
    tick();
    check("idle_after_rst", {oEntropyEn, oBusy}, 64'h0);

    // Normal word 0xB2
    load_bits(16'hB2, 8);
    iStart = 1'b1;
    tick();
    check("ent_rise", oEntropyEn, 1'b1);
    check("busy_warm", oBusy, 1'b1);
    wait_sample(20, n);
    check("first_se_delay", n, 6);
    tick();
    check("se_gap_low", oSampleEn, 1'b0);
    tick();
    check("se_period", oSampleEn, 1'b1);
    load_bits(16'hB2, 8);
    bits.delete();
    bits = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // remaining bits of 0xB2
    wait_valid(40, n);
    check("valid_delay", n, 14);
    check("word_b2", oData, 8'hB2);

    // Backpressure
    load_bits(16'h5A, 8);
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (oData !== 8'hB2 || oValid !== 1'b1 || oSampleEn !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", stable, 1'b1);
    iReady = 1'b1;
    tick();
    check("xfer_valid_low", oValid, 1'b0);
    iReady = 1'b0;
    tick();
    check("resume_se_low", oSampleEn, 1'b0);
    tick();
    check("resume_se", oSampleEn, 1'b1);
    wait_valid(40, n);
    check("valid2_delay", n, 16);
    check("word_5a", oData, 8'h5A);

    // Stop requested while holding: word still delivered, then idle
    iStart = 1'b0;
    tick();
    check("hold_keeps_valid", oValid, 1'b1);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check("hold_stop_idle", {oValid, oBusy, oEntropyEn}, 64'h0);

    // Health failure on 4th consecutive 1
    load_bits(16'h000F, 5);
    iStart = 1'b1;
    tick();
    wait_fail(40, n, sv);
    check("fail_delay", n, 16);
    check("fail_flag", oFail, 1'b1);
    check("fail_no_valid", sv, 1'b0);
    check("fail_outs", {oEntropyEn, oSampleEn, oValid, oBusy}, 64'h0);
    repeat (3) tick();
    check("fail_ignores_start", {oFail, oEntropyEn}, 64'h2);
    load_bits(16'h014F, 10);
    iClearFail = 1'b1;
    tick();
    iClearFail = 1'b0;
    check("clear_to_idle", {oFail, oEntropyEn}, 64'h0);
    tick();
    check("rewarm", oEntropyEn, 1'b1);

    // Cross-word run: 0x53 ends 1,1 then 1,1 starts the next word
    wait_valid(40, n);
    check("valid3_delay", n, 22);
    check("word_53", oData, 8'h53);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    wait_fail(40, n, sv);
    check("xword_fail_delay", n, 6);
    check("xword_fail", oFail, 1'b1);
    iStart = 1'b0;
    iClearFail = 1'b1;
    tick();
    iClearFail = 1'b0;
    tick();
    check("clear_stay_idle", {oFail, oEntropyEn}, 64'h0);

    // Stop mid-collect after 5 captures, then restart cleanly
    load_bits(16'h001A, 5);
    iStart = 1'b1;
    tick();
    repeat (16) tick();
    check("no_valid_partial", oValid, 1'b0);
    iStart = 1'b0;
    tick();
    check("stop_idle", {oEntropyEn, oSampleEn, oValid, oBusy}, 64'h0);
    load_bits(16'h0096, 8);
    iStart = 1'b1;
    tick();
    check("restart_ent", oEntropyEn, 1'b1);
    wait_sample(20, n);
    check("restart_warm", n, 6);
    wait_valid(40, n);
    check("restart_valid_delay", n, 16);
    check("word_96", oData, 8'h96);

    // Asynchronous reset while holding a word
    #2;
    iRstn = 1'b0;
    #1;
    check("async_rst_outs", {oEntropyEn, oSampleEn, oValid, oBusy, oFail, oData}, 64'h0);
    iStart = 1'b0;
    #2;
    iRstn = 1'b1;
    tick();
    check("post_rst_idle", {oEntropyEn, oBusy, oValid}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
